// File: rtl/gen_drain_if.sv
// Generator-side handshake bundle for gen_drain.
// master = consumer (gen_drain), slave = generator.
interface gen_drain_if #(
  parameter int WIDTH = 32
);
  logic             gen_start;
  logic [WIDTH-1:0] gen_base;
  logic [WIDTH-1:0] gen_limit;
  logic [WIDTH-1:0] gen_step;
  logic             gen_ready;
  logic             gen_valid;
  logic             gen_done;
  logic [WIDTH-1:0] gen_out0;
  logic [WIDTH-1:0] gen_out1;

  modport master (
    output gen_start, gen_base, gen_limit, gen_step, gen_ready,
    input  gen_valid, gen_done, gen_out0, gen_out1
  );

  modport slave (
    input  gen_start, gen_base, gen_limit, gen_step, gen_ready,
    output gen_valid, gen_done, gen_out0, gen_out1
  );
endinterface

// File: rtl/gen_drain.sv
// Consumer for two-output generators: launches one run,
// drains the tuple stream under a ready pattern, keeps stats.
module gen_drain #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             _clock,
  input  logic             _reset_n,
  input  logic             cmd_start,
  input  logic [WIDTH-1:0] cmd_base,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [7:0]       ready_mask,
  gen_drain_if.master      gen,
  output logic             busy,
  output logic             run_done,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] sum0,
  output logic [WIDTH-1:0] last0,
  output logic [WIDTH-1:0] last1,
  output logic             timeout
);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_COLLECT,
    S_FINISH
  } state_e;

  state_e           state_q;
  logic [7:0]       mask_q;
  logic [2:0]       phase_q;
  logic [IW-1:0]    idle_q;
  logic             start_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             tmo_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] last0_q;
  logic [WIDTH-1:0] last1_q;
  logic [CNT_W-1:0] cnt_q;

  logic             xfer;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] sum_d;

  assign xfer  = (state_q == S_COLLECT) && ready_q && gen.gen_valid;
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign sum_d = sum_q + gen.gen_out0;

  // Run FSM; all outputs registered, phase 0 is consumed in LAUNCH
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      phase_q <= '0;
      idle_q  <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      sum_q   <= '0;
      last0_q <= '0;
      last1_q <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            base_q  <= cmd_base;
            limit_q <= cmd_limit;
            step_q  <= cmd_step;
            mask_q  <= ready_mask;
            cnt_q   <= '0;
            sum_q   <= '0;
            last0_q <= '0;
            last1_q <= '0;
            tmo_q   <= 1'b0;
            phase_q <= '0;
            idle_q  <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          ready_q <= mask_q[0];
          phase_q <= 3'd1;
          state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          ready_q <= mask_q[phase_q];
          phase_q <= phase_q + 3'd1;
          if (xfer) begin
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            last0_q <= gen.gen_out0;
            last1_q <= gen.gen_out1;
            idle_q  <= '0;
          end
          if (gen.gen_done) begin
            ready_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else if (!xfer) begin
            if (idle_q == IW'(TIMEOUT)) begin
              tmo_q   <= 1'b1;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              idle_q <= idle_q + IW'(1);
            end
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gen.gen_start = start_q;
  assign gen.gen_base  = base_q;
  assign gen.gen_limit = limit_q;
  assign gen.gen_step  = step_q;
  assign gen.gen_ready = ready_q;
  assign busy          = busy_q;
  assign run_done      = done_q;
  assign count         = cnt_q;
  assign sum0          = sum_q;
  assign last0         = last0_q;
  assign last1         = last1_q;
  assign timeout       = tmo_q;
endmodule

// File: tb/tb_gen_drain.sv
// Directed bench for gen_drain with a behavioural hrange
// generator: yields (i, i) for i = base; i < limit; i += step.
module tb_gen_drain;
  logic        clk;
  logic        rst_n;
  logic        cmd_start;
  logic [31:0] cmd_base;
  logic [31:0] cmd_limit;
  logic [31:0] cmd_step;
  logic [7:0]  ready_mask;
  logic        busy;
  logic        run_done;
  logic [15:0] count;
  logic [31:0] sum0;
  logic [31:0] last0;
  logic [31:0] last1;
  logic        tmo;

  int total;
  int passed;

  gen_drain_if #(.WIDTH(32)) gif ();

  gen_drain #(
    .WIDTH  (32),
    .CNT_W  (16),
    .TIMEOUT(16)
  ) dut (
    ._clock    (clk),
    ._reset_n  (rst_n),
    .cmd_start (cmd_start),
    .cmd_base  (cmd_base),
    .cmd_limit (cmd_limit),
    .cmd_step  (cmd_step),
    .ready_mask(ready_mask),
    .gen       (gif),
    .busy      (busy),
    .run_done  (run_done),
    .count     (count),
    .sum0      (sum0),
    .last0     (last0),
    .last1     (last1),
    .timeout   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [31:0] g_cur;
  logic signed [31:0] g_lim;
  logic signed [31:0] g_stp;
  logic               g_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_run <= 1'b0;
      g_cur <= 0;
      g_lim <= 0;
      g_stp <= 0;
    end else if (gif.gen_start) begin
      g_run <= 1'b1;
      g_cur <= gif.gen_base;
      g_lim <= gif.gen_limit;
      g_stp <= gif.gen_step;
    end else if (gif.gen_valid && gif.gen_ready) begin
      g_cur <= g_cur + g_stp;
    end
  end

  assign gif.gen_valid = g_run && (g_cur < g_lim);
  assign gif.gen_done  = !g_run || (g_cur >= g_lim);
  assign gif.gen_out0  = g_cur;
  assign gif.gen_out1  = g_cur;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic start_run(input int b, input int l, input int s,
                           input logic [7:0] m);
    cmd_start  = 1'b1;
    cmd_base   = b;
    cmd_limit  = l;
    cmd_step   = s;
    ready_mask = m;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("launch_start", gif.gen_start, 1);
    chk("launch_busy", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (run_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, run_done, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, run_done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int k;
    total      = 0;
    passed     = 0;
    rst_n      = 1'b0;
    cmd_start  = 1'b0;
    cmd_base   = '0;
    cmd_limit  = '0;
    cmd_step   = '0;
    ready_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_gstart", gif.gen_start, 0);
    chk("rst_gready", gif.gen_ready, 0);
    chk("rst_tmo", tmo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // full throughput
    start_run(1, 11, 3, 8'hFF);
    chk("full_base", gif.gen_base, 1);
    chk("full_limit", gif.gen_limit, 11);
    chk("full_step", gif.gen_step, 3);
    wait_done("full");
    chk("full_count", count, 4);
    chk("full_sum", sum0, 22);
    chk("full_last0", last0, 10);
    chk("full_last1", last1, 10);
    chk("full_tmo", tmo, 0);

    // backpressure
    start_run(0, 10, 2, 8'b01010101);
    @(negedge clk);
    chk("bp_rdy0", gif.gen_ready, 1);
    @(negedge clk);
    chk("bp_rdy1", gif.gen_ready, 0);
    @(negedge clk);
    chk("bp_rdy2", gif.gen_ready, 1);
    @(negedge clk);
    chk("bp_rdy3", gif.gen_ready, 0);
    wait_done("bp");
    chk("bp_count", count, 5);
    chk("bp_sum", sum0, 20);
    chk("bp_last0", last0, 8);

    // empty run, stale done visible during LAUNCH
    start_run(5, 5, 1, 8'hFF);
    chk("empty_stale", gif.gen_done, 1);
    @(negedge clk);
    chk("empty_early", run_done, 0);
    chk("empty_busy", busy, 1);
    wait_done("empty");
    chk("empty_count", count, 0);
    chk("empty_sum", sum0, 0);
    chk("empty_tmo", tmo, 0);

    // timeout with no ready ever
    start_run(0, 10, 2, 8'h00);
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("to_rdy0", gif.gen_ready, 0);
      if (run_done === 1'b1) begin
        k = i;
        break;
      end
    end
    chk("to_latency", 64'(k), 64'(17));
    chk("to_flag", tmo, 1);
    chk("to_count", count, 0);
    @(negedge clk);
    chk("to_idle", busy, 0);

    // reset mid-run after two transfers
    start_run(0, 10, 2, 8'hFF);
    repeat (3) @(negedge clk);
    chk("mr_count2", count, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_count", count, 0);
    chk("mr_sum", sum0, 0);
    chk("mr_last0", last0, 0);
    chk("mr_gready", gif.gen_ready, 0);
    chk("mr_gbase", gif.gen_base, 0);
    chk("mr_done", run_done, 0);
    repeat (2) @(negedge clk);
    chk("mr_nodone", run_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(0, 10, 2, 8'hFF);
    wait_done("mr_rerun");
    chk("mr_rerun_count", count, 5);

    // start while busy ignored, then back-to-back
    start_run(1, 11, 3, 8'hFF);
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_base  = 100;
    cmd_limit = 200;
    cmd_step  = 7;
    @(negedge clk);
    @(negedge clk);
    cmd_start = 1'b0;
    chk("sb_base", gif.gen_base, 1);
    wait_done("sb");
    chk("sb_count", count, 4);
    chk("sb_sum", sum0, 22);
    start_run(0, 10, 2, 8'hFF);
    chk("b2b_base", gif.gen_base, 0);
    wait_done("b2b");
    chk("b2b_count", count, 5);
    chk("b2b_sum", sum0, 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gen_drain.md
# gen_drain

Caller-side consumer for the team's generator modules. Launches one generator run with three signed arguments and drains its `(_out0, _out1)` tuple stream over the ready/valid handshake. Backpressure follows a programmable ready pattern. Results are accumulated: count, running sum, last tuple, and a timeout flag. Used in simulation benches and on-chip self-test as the consuming end of any two-output generator.

## Interface
Parameters:
- `WIDTH`, 32: data width of arguments and tuple elements (signed)
- `CNT_W`, 16: width of the transfer counter
- `TIMEOUT`, 64: maximum consecutive COLLECT cycles with no transfer and no done before abort; must be ≥ 2

Ports (one clock; reset is asynchronous and active-low):
- `_clock` in 1: clock; all logic on the rising edge
- `_reset_n` in 1: asynchronous, active-low reset
- `cmd_start` in 1: request a run; sampled only in IDLE
- `cmd_base`, `cmd_limit`, `cmd_step` in WIDTH: run arguments, sampled with `cmd_start`
- `ready_mask` in 8: backpressure pattern, sampled with `cmd_start`
- `gen_start` out 1: generator start pulse
- `gen_base`, `gen_limit`, `gen_step` out WIDTH: registered arguments to the generator
- `gen_ready` out 1: consumer ready
- `gen_valid` in 1: generator output valid
- `gen_done` in 1: generator finished
- `gen_out0`, `gen_out1` in WIDTH: generator tuple
- `busy` out 1: high outside IDLE
- `run_done` out 1: one-cycle pulse at the end of a run
- `count` out CNT_W: number of transfers in the last run, saturating
- `sum0` out WIDTH: sum of `gen_out0` over the run, modulo 2^WIDTH
- `last0`, `last1` out WIDTH: most recent transferred tuple
- `timeout` out 1: last run was aborted by timeout

## Operation
States are IDLE, LAUNCH, COLLECT and FINISH.

- **IDLE:**
  - `cmd_start` = 1 → capture arguments into `gen_*` and `ready_mask` into an internal register.
  - Clear `count`, `sum0`, `last0`, `last1` and `timeout`, reset the phase counter and idle counter to 0, then go to LAUNCH.
- **LAUNCH** (exactly one cycle):
  - `gen_start` = 1, `gen_ready` = 0.
  - `gen_done` and `gen_valid` are ignored in this cycle, because the generator may still show done from its previous run.
  - Next state is COLLECT.
- **COLLECT:**
  - `gen_ready` = `mask[phase]`. The 3-bit phase increments every COLLECT cycle and wraps 7→0.
  - A transfer occurs at an edge where `gen_ready` and `gen_valid` are both 1. On a transfer:
    - `count` += 1, saturating at all-ones.
    - `sum0` += `gen_out0`, wrapping.
    - `last0`/`last1` ← `gen_out0`/`gen_out1`.
    - The idle counter is cleared.
  - `gen_done` = 1 at an edge → go to FINISH. If a transfer happens at the same edge, it is counted first.
  - Otherwise the idle counter increments. When it reaches `TIMEOUT`, set `timeout` = 1 and go to FINISH.
- **FINISH** (one cycle): `run_done` = 1, `gen_ready` = 0, then return to IDLE.
- `cmd_start` outside IDLE is ignored.
- Result outputs hold their values until the next accepted `cmd_start`.

## Timing
- **Reset:** assertion of `_reset_n` = 0 immediately forces state IDLE and clears every output, including `gen_*`, `busy`, `run_done`, `count`, `sum0`, `last0`, `last1` and `timeout`. This applies mid-run too; no `run_done` is emitted for an aborted run. Leaving reset returns to normal operation at the first rising edge.
- **Start to launch:** `gen_start` is high exactly one cycle, namely the cycle after the edge that accepted `cmd_start`. `busy` rises in the same cycle.
- **Registered outputs:** `gen_ready` is registered. Its first value is `mask[0]`, in the first COLLECT cycle.
- **Result updates:** results update at the transfer edge and are visible the following cycle.
- **End of run:** `run_done` is high the cycle after the edge where `gen_done` (or the timeout) was sampled. `busy` falls one cycle later.
- **Back-to-back runs:** throughput is one transfer per cycle with `ready_mask` = 8'hFF. A new `cmd_start` is accepted in the first IDLE cycle after FINISH.

## Test plan
- **Full throughput:** hrange (1, 11, 3), mask 8'hFF → `count` = 4, `sum0` = 22, `last0` = `last1` = 10, `timeout` = 0, a single `run_done` pulse.
- **Backpressure:** hrange (0, 10, 2), mask 8'b01010101 → `gen_ready` alternates 1,0 from the first COLLECT cycle; `count` = 5, `sum0` = 20, `last0` = 8; no tuple dropped or duplicated.
- **Empty run:** hrange (5, 5, 1) → `count` = 0, `sum0` = 0, `timeout` = 0. `run_done` is asserted, and a stale `gen_done` during LAUNCH does not end the run early.
- **Timeout:** mask 8'h00, `TIMEOUT` = 16, hrange (0, 10, 2) → `timeout` = 1 and `count` = 0. `run_done` occurs 17 cycles after the first COLLECT cycle.
- **Reset mid-run:** pull `_reset_n` low after 2 transfers → all outputs 0 immediately, `busy` = 0, no `run_done`. A new run, hrange (0, 10, 2) with mask 8'hFF, then gives `count` = 5.
- **Start while busy, then back-to-back:** `cmd_start` pulses during COLLECT are ignored, and the results match the original run's arguments. A `cmd_start` on the first IDLE cycle after FINISH is accepted.
